// File: rtl/motor_pkg.sv
// Shared definitions for the signed-command H-bridge PWM driver.
package motor_pkg;

  localparam int W_DEF = 11;
  localparam int M     = W_DEF - 1;
  localparam int PMAX  = (1 << M) - 1;

  typedef enum logic [1:0] {
    DRV_COAST = 2'd0,
    DRV_FWD   = 2'd1,
    DRV_REV   = 2'd2,
    DRV_BRAKE = 2'd3
  } drive_e;

  // Fold the single unrepresentable magnitude (-2^m) onto -(2^m-1) so |t| <= PMAX.
  function automatic logic signed [31:0] sat_cmd(input logic signed [31:0] c, input int m);
    logic signed [31:0] lo;
    lo = -(32'sd1 <<< m);
    if (c == lo) begin
      sat_cmd = lo + 32'sd1;
    end else begin
      sat_cmd = c;
    end
  endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// One motor channel: target saturation, slew-limited speed register and
// registered fwd/rev pin pair.
module motor_ramp_chan
  import motor_pkg::*;
#(
  parameter int W         = 11,
  parameter int RAMP_STEP = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-2:0] i_cnt,
  input  logic         i_tick,
  input  logic         i_en,
  input  logic         i_brake_en,
  input  logic [W-1:0] i_cmd,
  output logic [W-1:0] o_cur,
  output logic         o_fwd,
  output logic         o_rev
);

  localparam int M_W = W - 1;
  localparam logic signed [W:0] STEP_X = (W+1)'(RAMP_STEP);
  localparam logic signed [W:0] ZERO_X = (W+1)'(0);

  logic signed [31:0]  w_cmd32;
  logic signed [W-1:0] w_tgt;
  logic signed [W:0]   w_tgt_x;
  logic signed [W:0]   w_cur_x;
  logic signed [W:0]   w_sum;
  logic signed [W-1:0] w_cur_nxt;
  logic signed [W-1:0] r_cur;
  logic [M_W-1:0]      w_mag;
  drive_e              w_mode;
  logic                r_fwd;
  logic                r_rev;

  assign w_cmd32 = 32'($signed(i_cmd));
  assign w_tgt   = W'(sat_cmd(w_cmd32, M_W));
  assign w_tgt_x = (W+1)'(w_tgt);
  assign w_cur_x = (W+1)'(r_cur);

  // Next ramped speed: never crosses zero in one tick, otherwise slews toward the target.
  always_comb begin
    w_sum     = w_cur_x;
    w_cur_nxt = r_cur;
    if (r_cur == w_tgt) begin
      w_cur_nxt = r_cur;
    end else if ((r_cur[W-1] != w_tgt[W-1]) && (r_cur != '0)) begin
      if (r_cur[W-1]) begin
        w_sum = w_cur_x + STEP_X;
        if ((RAMP_STEP == 0) || (w_sum >= ZERO_X)) begin
          w_cur_nxt = '0;
        end else begin
          w_cur_nxt = W'(w_sum);
        end
      end else begin
        w_sum = w_cur_x - STEP_X;
        if ((RAMP_STEP == 0) || (w_sum <= ZERO_X)) begin
          w_cur_nxt = '0;
        end else begin
          w_cur_nxt = W'(w_sum);
        end
      end
    end else if (w_tgt_x > w_cur_x) begin
      w_sum = w_cur_x + STEP_X;
      if ((RAMP_STEP == 0) || (w_sum > w_tgt_x)) begin
        w_cur_nxt = w_tgt;
      end else begin
        w_cur_nxt = W'(w_sum);
      end
    end else begin
      w_sum = w_cur_x - STEP_X;
      if ((RAMP_STEP == 0) || (w_sum < w_tgt_x)) begin
        w_cur_nxt = w_tgt;
      end else begin
        w_cur_nxt = W'(w_sum);
      end
    end
  end

  // Applied speed: forced to zero while disabled, updated only on ramp ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur <= '0;
    end else if (!i_en) begin
      r_cur <= '0;
    end else if (i_tick) begin
      r_cur <= w_cur_nxt;
    end else begin
      r_cur <= r_cur;
    end
  end

  // Drive mode from enable, speed sign and the zero-speed brake/coast choice.
  always_comb begin
    w_mag = r_cur[W-1] ? M_W'(-r_cur) : M_W'(r_cur);
    if (!i_en) begin
      w_mode = DRV_COAST;
    end else if (r_cur == '0) begin
      w_mode = i_brake_en ? DRV_BRAKE : DRV_COAST;
    end else if (r_cur[W-1]) begin
      w_mode = DRV_REV;
    end else begin
      w_mode = DRV_FWD;
    end
  end

  // Registered bridge pins; only the brake mode may raise both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd <= 1'b0;
      r_rev <= 1'b0;
    end else begin
      case (w_mode)
        DRV_FWD: begin
          r_fwd <= (i_cnt < w_mag);
          r_rev <= 1'b0;
        end
        DRV_REV: begin
          r_fwd <= 1'b0;
          r_rev <= (i_cnt < w_mag);
        end
        DRV_BRAKE: begin
          r_fwd <= 1'b1;
          r_rev <= 1'b1;
        end
        default: begin
          r_fwd <= 1'b0;
          r_rev <= 1'b0;
        end
      endcase
    end
  end

  assign o_cur = r_cur;
  assign o_fwd = r_fwd;
  assign o_rev = r_rev;

endmodule

// File: rtl/motor_pwm_ramp.sv
// Multi-channel signed-command H-bridge PWM driver with slew limiting,
// zero-crossing brake interval and enable with brake/coast at zero.
module motor_pwm_ramp
  import motor_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int W         = W_DEF,
  parameter int RAMP_STEP = 64,
  parameter int RAMP_DIV  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             brake_en,
  input  logic [NCH*W-1:0] cmd,
  output logic [NCH*W-1:0] cur,
  output logic [NCH-1:0]   fwd,
  output logic [NCH-1:0]   rev,
  output logic             pstart
);

  localparam int M_W   = W - 1;
  localparam int P_MAX = (1 << M_W) - 1;
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [M_W-1:0]   CNT_LAST = M_W'(P_MAX - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  logic [M_W-1:0]   r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_pstart;
  logic             w_last;
  logic             w_tick;

  // A tick lands on the last count, so updated speeds take effect from cnt==0.
  assign w_last = (r_cnt == CNT_LAST);
  assign w_tick = w_last && (r_div == DIV_LAST);

  // Shared PWM counter (0..P_MAX-1), ramp divider and period-start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_div    <= '0;
      r_pstart <= 1'b0;
    end else begin
      if (w_last) begin
        r_cnt <= '0;
        if (r_div == DIV_LAST) begin
          r_div <= '0;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end else begin
        r_cnt <= r_cnt + M_W'(1);
        r_div <= r_div;
      end
      r_pstart <= (r_cnt == '0);
    end
  end

  assign pstart = r_pstart;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    motor_ramp_chan #(
      .W         (W),
      .RAMP_STEP (RAMP_STEP)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_cnt      (r_cnt),
      .i_tick     (w_tick),
      .i_en       (en),
      .i_brake_en (brake_en),
      .i_cmd      (cmd[gi*W +: W]),
      .o_cur      (cur[gi*W +: W]),
      .o_fwd      (fwd[gi]),
      .o_rev      (rev[gi])
    );
  end

endmodule
